// File: rtl/pp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pp_pkg
// Description : Shared state encoding and default widths for the P-vector
//               write packer (pp_write_packer / pp_lane_packer).
// Revision    : 1.0 - initial release
// ============================================================================
package pp_pkg;

    localparam int c_element_width          = 64;
    localparam int c_memories_address_width = 20;
    localparam int c_no_of_units            = 8;

    typedef enum logic [1:0] {
        PP_IDLE  = 2'd0,
        PP_FILL  = 2'd1,
        PP_FLUSH = 2'd2,
        PP_DONE  = 2'd3
    } pp_state_e;

    // Lane-index width; a single-lane word still needs a 1-bit index.
    function automatic int pp_lane_bits(input int units);
        return (units > 1) ? $clog2(units) : 1;
    endfunction

endpackage : pp_pkg
`default_nettype wire

// File: rtl/pp_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : pp_lane_packer
// Description : Lane-index counter and pack register. Places each accepted
//               element into the next lane and flags the word-complete edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_lane_packer
    import pp_pkg::*;
#(
    parameter int element_width = c_element_width,
    parameter int no_of_units   = c_no_of_units
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clear,
    input  logic                                 accept,
    input  logic [element_width-1:0]             element,
    output logic                                 word_complete,
    output logic [no_of_units*element_width-1:0] packed_word
);

    localparam int c_lane_bits = pp_lane_bits(no_of_units);
    localparam int c_word_bits = no_of_units * element_width;

    logic [c_lane_bits-1:0] r_lane;
    logic [c_word_bits-1:0] r_pack;
    logic [c_word_bits-1:0] w_next_pack;
    logic                   w_last_lane;

    assign w_last_lane   = (r_lane == c_lane_bits'(no_of_units - 1));
    assign word_complete = accept && w_last_lane;

    // Lane 0 starts a fresh word, so upper lanes are zeroed there; a partial
    // word read back later is then zero-filled above the last element.
    generate
        for (genvar k = 0; k < no_of_units; k++) begin : g_lane
            always_comb begin
                w_next_pack[k*element_width +: element_width] =
                    r_pack[k*element_width +: element_width];
                if (accept) begin
                    if (r_lane == c_lane_bits'(k)) begin
                        w_next_pack[k*element_width +: element_width] = element;
                    end else if (r_lane == '0) begin
                        w_next_pack[k*element_width +: element_width] = '0;
                    end
                end
            end
        end
    endgenerate

    assign packed_word = w_next_pack;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_lane <= '0;
            r_pack <= '0;
        end else if (accept) begin
            r_lane <= w_last_lane ? '0 : r_lane + c_lane_bits'(1);
            r_pack <= w_next_pack;
        end
    end

endmodule : pp_lane_packer
`default_nettype wire

// File: rtl/pp_write_packer.sv
`default_nettype none
// ============================================================================
// Module      : pp_write_packer
// Description : Packs no_of_units elements per memory word and writes words
//               to consecutive addresses; pulses finish at end of transfer.
//               Build option PP_PARTIAL_FLUSH_EN: write trailing partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module pp_write_packer
    import pp_pkg::*;
#(
    parameter int element_width          = c_element_width,
    parameter int memories_address_width = c_memories_address_width,
    parameter int no_of_units            = c_no_of_units,
    parameter int count_width            = memories_address_width + $clog2(no_of_units)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [memories_address_width-1:0]    base_address,
    input  logic [count_width-1:0]               element_count,
    input  logic                                 in_valid,
    input  logic [element_width-1:0]             in_data,
    output logic                                 in_ready,
    output logic                                 mem_write_enable,
    output logic [memories_address_width-1:0]    mem_write_address,
    output logic [no_of_units*element_width-1:0] mem_write_data,
    output logic                                 busy,
    output logic                                 finish
);

    logic [1:0]                          r_state;
    logic [count_width-1:0]              r_remaining;
    logic [memories_address_width-1:0]   r_addr;

    logic                                w_accept;
    logic                                w_clear;
    logic                                w_word_complete;
    logic [no_of_units*element_width-1:0] w_packed_word;

    assign in_ready = (r_state == PP_FILL);
    assign busy     = (r_state != PP_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_clear  = (r_state == PP_IDLE) && start;

    pp_lane_packer #(
        .element_width (element_width),
        .no_of_units   (no_of_units)
    ) u_lane_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (w_clear),
        .accept        (w_accept),
        .element       (in_data),
        .word_complete (w_word_complete),
        .packed_word   (w_packed_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= PP_IDLE;
            r_remaining       <= '0;
            r_addr            <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            finish            <= 1'b0;
        end else begin
            mem_write_enable <= 1'b0;
            case (r_state)
                PP_IDLE: begin
                    if (start) begin
                        if (element_count == '0) begin
                            // Empty transfer: report completion on the next cycle.
                            r_state <= PP_DONE;
                            finish  <= 1'b1;
                        end else begin
                            r_remaining <= element_count;
                            r_addr      <= base_address;
                            r_state     <= PP_FILL;
                        end
                    end
                end
                PP_FILL: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - count_width'(1);
                        if (w_word_complete) begin
                            mem_write_enable  <= 1'b1;
                            mem_write_address <= r_addr;
                            mem_write_data    <= w_packed_word;
                            r_addr            <= r_addr + memories_address_width'(1);
                        end
                        if (r_remaining == count_width'(1)) begin
                            r_state <= w_word_complete ? PP_DONE : PP_FLUSH;
                        end
                    end
                end
                PP_FLUSH: begin
`ifdef PP_PARTIAL_FLUSH_EN
                    // No element is accepted here, so packed_word is the
                    // zero-filled partial word.
                    mem_write_enable  <= 1'b1;
                    mem_write_address <= r_addr;
                    mem_write_data    <= w_packed_word;
                    r_addr            <= r_addr + memories_address_width'(1);
`endif
                    r_state <= PP_DONE;
                end
                PP_DONE: begin
                    // First DONE cycle lets the final write retire; finish follows.
                    if (finish) begin
                        finish  <= 1'b0;
                        r_state <= PP_IDLE;
                    end else begin
                        finish  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= PP_IDLE;
                end
            endcase
        end
    end

endmodule : pp_write_packer
`default_nettype wire

// File: tb/tb_pp_write_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_write_packer
// Description : Table-driven self-checking bench for pp_write_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_write_packer;
    import pp_pkg::*;

    localparam int EW = 64;
    localparam int AW = 20;
    localparam int NU = 8;
    localparam int CW = AW + 3;
    localparam int WB = NU * EW;

`ifdef PP_PARTIAL_FLUSH_EN
    localparam bit c_flush = 1'b1;
`else
    localparam bit c_flush = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic [CW-1:0] element_count;
    logic          in_valid;
    logic [EW-1:0] in_data;
    logic          in_ready;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_address;
    logic [WB-1:0] mem_write_data;
    logic          busy;
    logic          finish;

    pp_write_packer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_address      (base_address),
        .element_count     (element_count),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .busy              (busy),
        .finish            (finish)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] wq_addr[$];
    logic [WB-1:0] wq_data[$];
    int            wq_cyc[$];
    int            fq_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write_enable || finish) begin
            chk("we_finish_overlap", WB'(mem_write_enable && finish), '0);
            if (mem_write_enable) begin
                wq_addr.push_back(mem_write_address);
                wq_data.push_back(mem_write_data);
                wq_cyc.push_back(cyc);
            end
            if (finish) fq_cyc.push_back(cyc);
        end
    end

    function automatic logic [EW-1:0] elem(input int tag, input int i);
        return (64'(tag) << 32) | 64'(i);
    endfunction

    task automatic clear_queues();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        fq_cyc.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, WB'(in_ready), '0);
        chk({tag, "_we"},       WB'(mem_write_enable), '0);
        chk({tag, "_addr"},     WB'(mem_write_address), '0);
        chk({tag, "_data"},     mem_write_data, '0);
        chk({tag, "_busy"},     WB'(busy), '0);
        chk({tag, "_finish"},   WB'(finish), '0);
    endtask

    task automatic run_transfer(input int tag, input logic [AW-1:0] b, input int n,
                                input bit tog, input bit inj, input int exp_nw);
        int            s_cyc;
        int            acc[64];
        int            i;
        int            g;
        bit            rdy;
        bit            injected;
        int            rem;
        int            nfull;
        int            idx;
        int            exp_cyc;
        logic [WB-1:0] ed;
        injected = 1'b0;
        clear_queues();
        start         = 1'b1;
        base_address  = b;
        element_count = CW'(n);
        @(posedge clk); #1;
        s_cyc = cyc;
        start = 1'b0;
        i = 1;
        g = 0;
        while (i <= n && g < 200) begin
            in_valid = tog ? (g % 2 == 0) : 1'b1;
            in_data  = elem(tag, i);
            if (inj && i == 4 && !injected) begin
                start         = 1'b1;
                base_address  = 20'd100;
                element_count = CW'(1);
                injected      = 1'b1;
            end
            chk("in_ready_fill", WB'(in_ready), WB'(1));
            rdy = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (rdy) begin
                acc[i-1] = cyc;
                i++;
            end
            g++;
        end
        in_valid = 1'b0;
        if (i <= n) chk("feed_timeout", WB'(i), WB'(n + 1));
        repeat (6) @(posedge clk);
        #1;

        nfull = n / NU;
        rem   = n % NU;
        chk("num_writes", WB'(wq_addr.size()), WB'(exp_nw));
        for (int j = 0; j < exp_nw && j < wq_addr.size(); j++) begin
            ed = '0;
            for (int k = 0; k < NU; k++) begin
                idx = j * NU + k + 1;
                if (idx <= n) ed[k*EW +: EW] = elem(tag, idx);
            end
            exp_cyc = (j < nfull) ? acc[j*NU + NU - 1] : acc[n-1] + 1;
            chk("write_addr", WB'(wq_addr[j]), WB'(AW'(b + AW'(j))));
            chk("write_data", wq_data[j], ed);
            chk("write_cycle", WB'(wq_cyc[j]), WB'(exp_cyc));
        end
        chk("finish_count", WB'(fq_cyc.size()), WB'(1));
        if (fq_cyc.size() >= 1) begin
            exp_cyc = (n == 0) ? s_cyc : ((rem == 0) ? acc[n-1] + 1 : acc[n-1] + 2);
            chk("finish_cycle", WB'(fq_cyc[0]), WB'(exp_cyc));
        end
        chk("busy_after", WB'(busy), '0);
        chk("in_ready_after", WB'(in_ready), '0);
        if (exp_nw > 0) chk("addr_hold", WB'(mem_write_address), WB'(AW'(b + AW'(exp_nw - 1))));
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            count;
        bit            toggle;
        bit            inject;
        int            nw_plain;
        int            nw_flush;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{base: 20'd10,      count: 16, toggle: 0, inject: 0, nw_plain: 2, nw_flush: 2};
        vecs[1] = '{base: 20'd40,      count: 8,  toggle: 1, inject: 0, nw_plain: 1, nw_flush: 1};
        vecs[2] = '{base: 20'd0,       count: 11, toggle: 0, inject: 0, nw_plain: 1, nw_flush: 2};
        vecs[3] = '{base: 20'hFFFFF,   count: 16, toggle: 0, inject: 0, nw_plain: 2, nw_flush: 2};
        vecs[4] = '{base: 20'd20,      count: 8,  toggle: 0, inject: 1, nw_plain: 1, nw_flush: 1};
        vecs[5] = '{base: 20'd7,       count: 0,  toggle: 0, inject: 0, nw_plain: 0, nw_flush: 0};
        vecs[6] = '{base: 20'd5,       count: 3,  toggle: 0, inject: 0, nw_plain: 0, nw_flush: 1};

        reset         = 1'b1;
        start         = 1'b0;
        base_address  = '0;
        element_count = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_init");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            run_transfer(v, vecs[v].base, vecs[v].count, vecs[v].toggle, vecs[v].inject,
                         c_flush ? vecs[v].nw_flush : vecs[v].nw_plain);
        end

        // Reset partway through a word: nothing may be written.
        clear_queues();
        start         = 1'b1;
        base_address  = 20'd0;
        element_count = CW'(8);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = elem(9, k);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset_mid");
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("reset_mid_no_write", WB'(wq_addr.size()), '0);
        chk("reset_mid_no_finish", WB'(fq_cyc.size()), '0);

        run_transfer(10, 20'd3, 8, 1'b0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_pp_write_packer
`default_nettype wire

// File: doc/pp_write_packer.md
# pp_write_packer

Serialising write stage that feeds the P-vector memory bank. It accepts one `element_width`-bit element per cycle from the upstream update datapath and packs `no_of_units` consecutive elements into one memory word. It then drives the memory's write port (`write_enable`, `input_write_address`, `input_data`) with consecutive addresses from a programmed base, and pulses `finish` once the last word has been captured.

## Interface

Parameters:
- `element_width`, 64, width of one vector element
- `memories_address_width`, 20, memory word-address width
- `no_of_units`, 8, elements per memory word (power of two)
- `count_width`, `memories_address_width + $clog2(no_of_units)`, element-count width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; loads `base_address` and `element_count`; honoured only in IDLE
- `base_address`  in  `memories_address_width`  first word address to write
- `element_count`  in  `count_width`  total elements in this transfer
- `in_valid`  in  1  upstream element present
- `in_data`  in  `element_width`  upstream element
- `in_ready`  out  1  element accepted on edge where `in_valid && in_ready`
- `mem_write_enable`  out  1  to memory `write_enable`
- `mem_write_address`  out  `memories_address_width`  to memory `input_write_address`
- `mem_write_data`  out  `no_of_units*element_width`  to memory `input_data`
- `busy`  out  1  high outside IDLE
- `finish`  out  1  one-cycle pulse at end of transfer

## Operation

- States: IDLE, FILL, FLUSH, DONE.
- IDLE: `in_ready`=0. On `start` with `element_count`=0, go to DONE. On `start` with a non-zero count, latch count and address, clear the lane index, and go to FILL.
- FILL: `in_ready`=1. Each accepted element goes into pack-register lane k, bits `[k*element_width +: element_width]`. Lane 0 is the lowest and the first element. k increments; the remaining count decrements.
- Word complete: the edge that accepts lane `no_of_units-1` copies the pack register plus that element into the output register. `mem_write_enable`=1 for exactly the next cycle at the current address. The address then increments modulo 2^`memories_address_width` (wraps silently). k returns to 0.
- The pack and output registers are separate, so FILL continues with no bubble; sustained throughput is 1 element per cycle.
- Last element accepted:
  - On a word boundary, the final write is issued as above and the FSM goes to DONE on the same edge.
  - Otherwise it goes to FLUSH.
- FLUSH: behaviour set by the macro (see Configuration). Lasts 1 cycle, then DONE.
- DONE: `finish`=1 for one cycle, then IDLE. `finish` is never coincident with the final `mem_write_enable`; it follows it by one cycle.
- `start` outside IDLE is ignored. `in_valid` outside FILL is ignored and not consumed.
- `reset` (at any time, including mid-transfer): go to IDLE. All outputs 0: `in_ready`, `mem_write_enable`, `mem_write_address`, `mem_write_data`, `busy`, `finish`. Partial pack contents are discarded; no write is issued.

## Timing

- Element accepted at edge t as lane `no_of_units-1`: `mem_write_enable` is high in cycle (t, t+1], and the memory captures at edge t+1.
- Transfer of N elements (N a multiple of `no_of_units`, no stalls), with `start` at edge 0:
  - First acceptance at edge 1.
  - Last acceptance at edge N.
  - Final write enable in cycle (N, N+1].
  - `finish` in cycle (N+1, N+2].
  - IDLE from edge N+2.
- `mem_write_address`/`mem_write_data` are registered and stable throughout the enable cycle. They hold their last values when the enable is low.
- `element_count`=0: `finish` is high in the cycle after the `start` edge; no write is issued.

## Configuration

- `PP_PARTIAL_FLUSH_EN` defined:
  - FLUSH writes the partial word, with unused upper lanes zero-filled, at the next address.
  - The write enable is high during the cycle after entering FLUSH; `finish` follows.
- Undefined:
  - FLUSH issues no write; the trailing partial elements are dropped.
  - The address is not advanced; `finish` still pulses.

## Structure

- Shared package `pp_pkg`:
  - State enum (`PP_IDLE`, `PP_FILL`, `PP_FLUSH`, `PP_DONE`).
  - Default width constants (64, 20, 8).
- One natural sub-module, `pp_lane_packer`: lane-index counter plus pack register with lane-select write. Outputs the word-complete strobe and the packed word.
- FSM, counters and the output register live in the top.

## Test plan

- Reset, then `start` with base 10, count 16, data 1..16 back-to-back:
  - Writes at addr 10 (data lanes 0..7 = 1..8, lane 0 lowest), then at addr 11 (lanes = 9..16).
  - `finish` pulses at cycle 18 after start.
- Count 8 with `in_valid` toggling every other cycle: one write only, on the cycle after the 8th acceptance; `in_ready` stays 1 during FILL.
- Count 11, base 0:
  - With the macro: second write at addr 1, lanes 0..2 = elements 9..11, lanes 3..7 = 0.
  - Without the macro: a single write only.
- Base 2^20-1, count 16: writes at 0xFFFFF then 0x00000.
- `reset` asserted after 5 of 8 elements: no write, all outputs 0 next cycle. A following transfer (base 3, count 8) writes correctly at addr 3.
- `start` pulsed while in FILL: ignored (count and address unchanged). Count 0 `start`: `finish` 1 cycle later, no write.
